// File: rtl/sprite_compositor.sv
// Sprite compositor: double-buffered rectangular sprite descriptors, 4-stage
// hit/address/RAM/output pipeline. Optional sticky collision status: SPRITE_COLLISION_EN.
module sprite_compositor #(
  parameter int N_SPRITES  = 4,
  parameter int COORD_W    = 10,
  parameter int LAYER_W    = 2,
  parameter int RAM_ADDR_W = 16,
  parameter int COLOR_W    = 12,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_areset,
  input  logic                  reg_wr_en,
  input  logic [REG_ADDR_W-1:0] reg_addr,
  input  logic [31:0]           reg_wdata,
  input  logic                  reg_rd_en,
  output logic [31:0]           reg_rdata,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [COORD_W-1:0]    pix_x,
  input  logic [COORD_W-1:0]    pix_y,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_rd_en,
  input  logic [COLOR_W-1:0]    ram_rdata,
  output logic [COLOR_W-1:0]    pixel_out,
  output logic                  pixel_out_valid
);

  typedef struct packed {
    logic [COORD_W-1:0]    x1;
    logic [COORD_W-1:0]    y1;
    logic [COORD_W-1:0]    x2;
    logic [COORD_W-1:0]    y2;
    logic [LAYER_W-1:0]    layer;
    logic [RAM_ADDR_W-1:0] base;
  } desc_t;

  // Descriptor state: shadow (register writes) and active (used by the pipeline)
  desc_t                sh_desc_q  [N_SPRITES];
  desc_t                sh_desc_d  [N_SPRITES];
  desc_t                act_desc_q [N_SPRITES];
  desc_t                act_desc_d [N_SPRITES];
  logic [COLOR_W-1:0]   sh_bg_q, sh_bg_d, act_bg_q, act_bg_d;
  logic [N_SPRITES-1:0] sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic [31:0]          reg_rdata_q, reg_rdata_d;

  // Pipeline state
  logic                  s1_valid_q, s1_valid_d, s1_hit_q, s1_hit_d;
  logic [COORD_W-1:0]    s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;
  logic [COORD_W:0]      s1_width_q, s1_width_d;
  logic [RAM_ADDR_W-1:0] s1_base_q, s1_base_d;
  logic [COLOR_W-1:0]    s1_bg_q, s1_bg_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [COLOR_W-1:0]    s2_bg_q, s2_bg_d;
  logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_rd_en_q, ram_rd_en_d;
  logic                  s3_valid_q, s3_valid_d, s3_hit_q, s3_hit_d;
  logic [COLOR_W-1:0]    s3_bg_q, s3_bg_d;
  logic [COLOR_W-1:0]    pixel_out_q, pixel_out_d;
  logic                  pixel_out_valid_q, pixel_out_valid_d;

  logic [N_SPRITES-1:0]  hit_vec;
  logic [LAYER_W-1:0]    best_layer;
  logic                  unused_wdata_bits;

  assign unused_wdata_bits = ^reg_wdata;

`ifdef SPRITE_COLLISION_EN
  logic                 coll_q, coll_d;
  logic [N_SPRITES-1:0] part_q, part_d;
  logic                 multi_hit;
  logic [31:0]          status_word;

  assign status_word = (32'(part_q) << 8) | 32'(coll_q);

  always_comb begin
    multi_hit = |(hit_vec & (hit_vec - N_SPRITES'(1)));
    coll_d    = coll_q;
    part_d    = part_q;
    if (reg_rd_en && reg_addr == REG_ADDR_W'(2)) begin
      coll_d = 1'b0;
      part_d = '0;
    end
    // A new collision in the clearing cycle is applied after the clear, so it survives
    if (pix_valid && multi_hit) begin
      coll_d = 1'b1;
      part_d = part_d | hit_vec;
    end
  end
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sh_bg_d   = sh_bg_q;
    sh_en_d   = sh_en_q;
    sh_desc_d = sh_desc_q;
    if (reg_wr_en) begin
      if (reg_addr == REG_ADDR_W'(0)) sh_bg_d = reg_wdata[COLOR_W-1:0];
      if (reg_addr == REG_ADDR_W'(1)) sh_en_d = reg_wdata[N_SPRITES-1:0];
      for (int i = 0; i < N_SPRITES; i++) begin
        if (reg_addr == REG_ADDR_W'(4 + 3*i)) begin
          sh_desc_d[i].y1 = reg_wdata[0 +: COORD_W];
          sh_desc_d[i].x1 = reg_wdata[COORD_W +: COORD_W];
          sh_desc_d[i].y2 = reg_wdata[2*COORD_W +: COORD_W];
        end
        if (reg_addr == REG_ADDR_W'(5 + 3*i)) begin
          sh_desc_d[i].x2    = reg_wdata[0 +: COORD_W];
          sh_desc_d[i].layer = reg_wdata[COORD_W +: LAYER_W];
        end
        if (reg_addr == REG_ADDR_W'(6 + 3*i)) sh_desc_d[i].base = reg_wdata[RAM_ADDR_W-1:0];
      end
    end
  end

  // Active copy takes the pre-write shadow, so a coincident write waits one frame
  always_comb begin
    act_desc_d = frame_start ? sh_desc_q : act_desc_q;
    act_bg_d   = frame_start ? sh_bg_q   : act_bg_q;
    act_en_d   = frame_start ? sh_en_q   : act_en_q;
  end

  always_comb begin
    reg_rdata_d = reg_rdata_q;
    if (reg_rd_en) begin
      reg_rdata_d = '0;
      if (reg_addr == REG_ADDR_W'(0)) reg_rdata_d = 32'(sh_bg_q);
      if (reg_addr == REG_ADDR_W'(1)) reg_rdata_d = 32'(sh_en_q);
`ifdef SPRITE_COLLISION_EN
      if (reg_addr == REG_ADDR_W'(2)) reg_rdata_d = status_word;
`endif
      for (int i = 0; i < N_SPRITES; i++) begin
        if (reg_addr == REG_ADDR_W'(4 + 3*i))
          reg_rdata_d = (32'(sh_desc_q[i].y2) << (2*COORD_W)) |
                        (32'(sh_desc_q[i].x1) << COORD_W) | 32'(sh_desc_q[i].y1);
        if (reg_addr == REG_ADDR_W'(5 + 3*i))
          reg_rdata_d = (32'(sh_desc_q[i].layer) << COORD_W) | 32'(sh_desc_q[i].x2);
        if (reg_addr == REG_ADDR_W'(6 + 3*i)) reg_rdata_d = 32'(sh_desc_q[i].base);
      end
    end
  end

  // Stage 1: hit test and priority pick; the winner's base and width travel with the pixel
  always_comb begin
    hit_vec    = '0;
    best_layer = '0;
    s1_hit_d   = 1'b0;
    s1_dx_d    = '0;
    s1_dy_d    = '0;
    s1_base_d  = '0;
    s1_width_d = '0;
    s1_valid_d = pix_valid;
    s1_bg_d    = act_bg_q;
    for (int i = 0; i < N_SPRITES; i++) begin
      hit_vec[i] = act_en_q[i] &&
                   (act_desc_q[i].x1 <= pix_x) && (pix_x <= act_desc_q[i].x2) &&
                   (act_desc_q[i].y1 <= pix_y) && (pix_y <= act_desc_q[i].y2);
    end
    // Strict greater-than keeps the lowest index on equal layers
    for (int i = 0; i < N_SPRITES; i++) begin
      if (hit_vec[i] && (!s1_hit_d || act_desc_q[i].layer > best_layer)) begin
        s1_hit_d   = 1'b1;
        best_layer = act_desc_q[i].layer;
        s1_dx_d    = pix_x - act_desc_q[i].x1;
        s1_dy_d    = pix_y - act_desc_q[i].y1;
        s1_base_d  = act_desc_q[i].base;
        s1_width_d = {1'b0, act_desc_q[i].x2} - {1'b0, act_desc_q[i].x1} + (COORD_W+1)'(1);
      end
    end
  end

  // Stages 2-4: address, RAM access, output select
  always_comb begin
    s2_valid_d  = s1_valid_q;
    s2_bg_d     = s1_bg_q;
    ram_rd_en_d = s1_valid_q && s1_hit_q;
    ram_addr_d  = ram_addr_q;
    if (s1_valid_q && s1_hit_q)
      ram_addr_d = s1_base_q + RAM_ADDR_W'(s1_dy_q) * RAM_ADDR_W'(s1_width_q)
                 + RAM_ADDR_W'(s1_dx_q);
    s3_valid_d        = s2_valid_q;
    s3_hit_d          = ram_rd_en_q;
    s3_bg_d           = s2_bg_q;
    pixel_out_valid_d = s3_valid_q;
    pixel_out_d       = s3_hit_q ? ram_rdata : s3_bg_q;
  end

  // NOTE: descriptor arrays are ordinary flops, so reset must clear them explicitly element by element.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        sh_desc_q[i]  <= '0;
        act_desc_q[i] <= '0;
      end
      sh_bg_q           <= '0;
      act_bg_q          <= '0;
      sh_en_q           <= '0;
      act_en_q          <= '0;
      reg_rdata_q       <= '0;
      s1_valid_q        <= 1'b0;
      s1_hit_q          <= 1'b0;
      s1_dx_q           <= '0;
      s1_dy_q           <= '0;
      s1_width_q        <= '0;
      s1_base_q         <= '0;
      s1_bg_q           <= '0;
      s2_valid_q        <= 1'b0;
      s2_bg_q           <= '0;
      ram_addr_q        <= '0;
      ram_rd_en_q       <= 1'b0;
      s3_valid_q        <= 1'b0;
      s3_hit_q          <= 1'b0;
      s3_bg_q           <= '0;
      pixel_out_q       <= '0;
      pixel_out_valid_q <= 1'b0;
`ifdef SPRITE_COLLISION_EN
      coll_q            <= 1'b0;
      part_q            <= '0;
`endif
    end else begin
      sh_desc_q         <= sh_desc_d;
      act_desc_q        <= act_desc_d;
      sh_bg_q           <= sh_bg_d;
      act_bg_q          <= act_bg_d;
      sh_en_q           <= sh_en_d;
      act_en_q          <= act_en_d;
      reg_rdata_q       <= reg_rdata_d;
      s1_valid_q        <= s1_valid_d;
      s1_hit_q          <= s1_hit_d;
      s1_dx_q           <= s1_dx_d;
      s1_dy_q           <= s1_dy_d;
      s1_width_q        <= s1_width_d;
      s1_base_q         <= s1_base_d;
      s1_bg_q           <= s1_bg_d;
      s2_valid_q        <= s2_valid_d;
      s2_bg_q           <= s2_bg_d;
      ram_addr_q        <= ram_addr_d;
      ram_rd_en_q       <= ram_rd_en_d;
      s3_valid_q        <= s3_valid_d;
      s3_hit_q          <= s3_hit_d;
      s3_bg_q           <= s3_bg_d;
      pixel_out_q       <= pixel_out_d;
      pixel_out_valid_q <= pixel_out_valid_d;
`ifdef SPRITE_COLLISION_EN
      coll_q            <= coll_d;
      part_q            <= part_d;
`endif
    end
  end

  assign reg_rdata       = reg_rdata_q;
  assign ram_addr        = ram_addr_q;
  assign ram_rd_en       = ram_rd_en_q;
  assign pixel_out       = pixel_out_q;
  assign pixel_out_valid = pixel_out_valid_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: table vectors plus a scoreboard fed
// by a small reference model of the shadow/active descriptors and the pixel RAM.
module tb_sprite_compositor;
  localparam int N  = 4;
  localparam int CW = 10;
  localparam int AW = 16;
  localparam int PW = 12;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          reg_wr_en, reg_rd_en, frame_start, pix_valid;
  logic [RW-1:0] reg_addr;
  logic [31:0]   reg_wdata, reg_rdata;
  logic [CW-1:0] pix_x, pix_y;
  logic [AW-1:0] ram_addr;
  logic          ram_rd_en, pixel_out_valid;
  logic [PW-1:0] ram_rdata = '0;
  logic [PW-1:0] pixel_out;

  sprite_compositor #(
    .N_SPRITES(N), .COORD_W(CW), .LAYER_W(2), .RAM_ADDR_W(AW), .COLOR_W(PW), .REG_ADDR_W(RW)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata),
    .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_rdata(ram_rdata),
    .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] ram_fn(input logic [AW-1:0] a);
    return a[PW-1:0] ^ 12'h12B;
  endfunction

  // Pixel RAM: data one cycle after the read enable
  always @(posedge clk) if (ram_rd_en === 1'b1) ram_rdata <= ram_fn(ram_addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  logic [AW-1:0] addr_q[$];
  logic [PW-1:0] pix_q[$];

  always @(negedge clk) begin
    if (ram_rd_en === 1'b1) begin
      if (addr_q.size() == 0) check("ram_rd_en unexpected", 32'(ram_rd_en), 32'd0);
      else check("ram_addr", 32'(ram_addr), 32'(addr_q.pop_front()));
    end
    if (pixel_out_valid === 1'b1) begin
      if (pix_q.size() == 0) check("pixel_out_valid unexpected", 32'(pixel_out_valid), 32'd0);
      else check("pixel_out", 32'(pixel_out), 32'(pix_q.pop_front()));
    end
  end

  // Reference model of the register file
  typedef struct { int x1, y1, x2, y2, layer, base; } mdesc_t;
  mdesc_t     m_sh[N], m_act[N];
  int         m_sh_bg, m_act_bg;
  bit [N-1:0] m_sh_en, m_act_en;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_sh[i]  = '{0, 0, 0, 0, 0, 0};
      m_act[i] = '{0, 0, 0, 0, 0, 0};
    end
    m_sh_bg = 0; m_act_bg = 0; m_sh_en = '0; m_act_en = '0;
  endfunction

  function automatic void model_commit();
    m_act = m_sh; m_act_bg = m_sh_bg; m_act_en = m_sh_en;
  endfunction

  function automatic void model_write(input int a, input logic [31:0] d);
    if (a == 0) m_sh_bg = int'(d[11:0]);
    if (a == 1) m_sh_en = d[N-1:0];
    for (int i = 0; i < N; i++) begin
      if (a == 4 + 3*i) begin
        m_sh[i].y1 = int'(d[9:0]); m_sh[i].x1 = int'(d[19:10]); m_sh[i].y2 = int'(d[29:20]);
      end
      if (a == 5 + 3*i) begin m_sh[i].x2 = int'(d[9:0]); m_sh[i].layer = int'(d[11:10]); end
      if (a == 6 + 3*i) m_sh[i].base = int'(d[15:0]);
    end
  endfunction

  task automatic push_expect(input int x, input int y);
    bit hit = 0;
    int best = 0, w = 0, addr;
    for (int i = 0; i < N; i++)
      if (m_act_en[i] && x >= m_act[i].x1 && x <= m_act[i].x2 && y >= m_act[i].y1 && y <= m_act[i].y2)
        if (!hit || m_act[i].layer > best) begin hit = 1; best = m_act[i].layer; w = i; end
    if (hit) begin
      addr = (m_act[w].base + (y - m_act[w].y1) * (m_act[w].x2 - m_act[w].x1 + 1) + (x - m_act[w].x1)) & 'hFFFF;
      addr_q.push_back(AW'(addr));
      pix_q.push_back(ram_fn(AW'(addr)));
    end else pix_q.push_back(PW'(m_act_bg));
  endtask

  task automatic drive_pix(input int x, input int y);
    pix_valid = 1'b1; pix_x = CW'(x); pix_y = CW'(y);
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic req(input int x, input int y);
    push_expect(x, y);
    drive_pix(x, y);
  endtask

  task automatic reg_write(input int a, input logic [31:0] d);
    model_write(a, d);
    reg_wr_en = 1'b1; reg_addr = RW'(a); reg_wdata = d;
    @(posedge clk); #1;
    reg_wr_en = 1'b0;
  endtask

  task automatic fs();
    model_commit();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic reg_write_fs(input int a, input logic [31:0] d);
    model_commit();
    model_write(a, d);
    reg_wr_en = 1'b1; frame_start = 1'b1; reg_addr = RW'(a); reg_wdata = d;
    @(posedge clk); #1;
    reg_wr_en = 1'b0; frame_start = 1'b0;
  endtask

  task automatic reg_read(input int a, input logic [31:0] exp, input string name);
    reg_rd_en = 1'b1; reg_addr = RW'(a);
    @(posedge clk); #1;
    reg_rd_en = 1'b0;
    check(name, reg_rdata, exp);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && (pix_q.size() != 0 || addr_q.size() != 0); k++) @(posedge clk);
    @(posedge clk); #1;
    check(name, 32'(pix_q.size() + addr_q.size()), 32'd0);
    pix_q.delete(); addr_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, " ram_rd_en"}, 32'(ram_rd_en), 32'd0);
    check({tag, " pixel_out"}, 32'(pixel_out), 32'd0);
    check({tag, " pixel_out_valid"}, 32'(pixel_out_valid), 32'd0);
    check({tag, " reg_rdata"}, reg_rdata, 32'd0);
  endtask

  function automatic logic [31:0] w_rect(input int x1, input int y1, input int y2);
    return (32'(y2) << 20) | (32'(x1) << 10) | 32'(y1);
  endfunction

  typedef struct { int x, y; bit hit; int addr; int pix; } vec_t;
  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Hand-derived vectors: sprite0 40..45 x 50..52 base 0, sprite2 inverted, sprite3 wraps at 0xFFFE
    tbl[0]  = '{42, 51, 1, 8, 'h123};    tbl[1]  = '{40, 50, 1, 0, 'h12B};
    tbl[2]  = '{45, 52, 1, 17, 'h13A};   tbl[3]  = '{44, 50, 1, 4, 'h12F};
    tbl[4]  = '{39, 51, 0, 0, 'hABC};    tbl[5]  = '{46, 51, 0, 0, 'hABC};
    tbl[6]  = '{45, 53, 0, 0, 'hABC};    tbl[7]  = '{40, 49, 0, 0, 'hABC};
    tbl[8]  = '{95, 51, 0, 0, 'hABC};    tbl[9]  = '{100, 51, 0, 0, 'hABC};
    tbl[10] = '{205, 203, 1, 'h21, 'h10A}; tbl[11] = '{209, 209, 1, 'h61, 'h14A};

    model_reset();
    rst = 1'b1; reg_wr_en = 0; reg_rd_en = 0; frame_start = 0; pix_valid = 0;
    reg_addr = '0; reg_wdata = '0; pix_x = '0; pix_y = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // No sprites enabled: background reset value, no RAM reads
    req(10, 10);
    drain("drain idle");

    reg_write(0, 32'hABC);
    reg_write(4, w_rect(40, 50, 52));   reg_write(5, 32'd45);          reg_write(6, 32'd0);
    reg_write(10, w_rect(100, 0, 500)); reg_write(11, (3 << 10) | 90); reg_write(12, 32'h500);
    reg_write(13, w_rect(200, 200, 209)); reg_write(14, 32'd209);      reg_write(15, 32'hFFFE);
    reg_write(1, 32'hD);
    reg_write(31, 32'hFFFF_FFFF);
    reg_read(0, 32'hABC, "rd bg");
    reg_read(1, 32'hD, "rd enable");
    reg_read(4, w_rect(40, 50, 52), "rd sprite0 rect");
    reg_read(11, (3 << 10) | 90, "rd sprite2 layer/x2");
    reg_read(15, 32'hFFFE, "rd sprite3 base");
    reg_read(3, 32'd0, "rd unmapped 3");
    reg_read(31, 32'd0, "rd unmapped 31");
    fs();

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].hit) addr_q.push_back(AW'(tbl[i].addr));
      pix_q.push_back(PW'(tbl[i].pix));
      drive_pix(tbl[i].x, tbl[i].y);
    end
    drain("drain table");

    // Priority: sprite1 on a higher layer wins the overlap
    reg_write(5, (1 << 10) | 45);
    reg_write(7, w_rect(41, 48, 60)); reg_write(8, (3 << 10) | 50); reg_write(9, 32'h1000);
    reg_write(1, 32'hF);
    fs();
    req(42, 51);
`ifdef SPRITE_COLLISION_EN
    reg_read(2, 32'h301, "status collision");
`else
    reg_read(2, 32'h0, "status collision");
`endif
    reg_read(2, 32'h0, "status after clear");
    reg_write(8, (1 << 10) | 50);
    fs();
    req(42, 51); req(48, 51);
    drain("drain priority");

    // Shadowing: write without commit, commit, coincident write+commit
    reg_write(4, w_rect(0, 50, 52));
    req(42, 51); req(10, 51);
    fs();
    req(42, 51); req(10, 51);
    reg_write_fs(4, w_rect(40, 50, 52));
    req(42, 51);
    fs();
    req(42, 51);
    drain("drain shadow");

    // Reset during a back-to-back stream drops in-flight pixels and clears the registers
    for (int c = 0; c < 64; c++) begin
      rst = (c == 20);
      if (c == 20) model_reset();
      else push_expect(38 + c % 10, 51);
      pix_valid = 1'b1; pix_x = CW'(38 + c % 10); pix_y = CW'(51);
      @(posedge clk); #1;
      if (c == 20) begin
        addr_q.delete(); pix_q.delete();
        check_all_zero("mid-stream reset");
      end
      if (c > 20 && c <= 23) check("valid after reset", 32'(pixel_out_valid), 32'd0);
    end
    rst = 1'b0; pix_valid = 1'b0;
    drain("drain reset stream");

    reg_write(0, 32'h0F0);
    reg_write(4, w_rect(5, 5, 5)); reg_write(5, 32'd7); reg_write(6, 32'h20);
    reg_write(1, 32'h1);
    fs();
    req(6, 5); req(8, 5);
    drain("drain recovery");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor to the fixed 4-blob GPU datapath.
- Holds N_SPRITES rectangular sprite descriptors with layer priority. Descriptors are double-buffered and committed at frame start.
- For each requested screen coordinate it selects the top sprite, issues a pixel-RAM read, and returns a COLOR_W pixel after a fixed pipeline latency.
- Sits between the AXI-lite register front-end and the VGA timing generator / pixel RAM.

Parameters:
- N_SPRITES, 4, number of sprite descriptors (1..8).
- COORD_W, 10, coordinate width for x and y.
- LAYER_W, 2, layer field width; larger value is nearer the viewer.
- RAM_ADDR_W, 16, pixel-RAM word address width.
- COLOR_W, 12, pixel colour width (RGB444 by default).
- REG_ADDR_W, 5, register word-index width; 4+3*N_SPRITES must be <= 2**REG_ADDR_W.

Ports:
- s00_axi_aclk  in  1  single clock.
- s00_axi_areset  in  1  synchronous active-high reset.
- reg_wr_en  in  1  register write strobe, one word per cycle.
- reg_addr  in  REG_ADDR_W  register word index.
- reg_wdata  in  32  write data.
- reg_rd_en  in  1  register read strobe.
- reg_rdata  out  32  read data, valid 1 cycle after reg_rd_en.
- frame_start  in  1  one-cycle pulse at the start of vertical blanking.
- pix_valid  in  1  pixel request.
- pix_x  in  COORD_W  requested column.
- pix_y  in  COORD_W  requested row.
- ram_addr  out  RAM_ADDR_W  pixel-RAM read address.
- ram_rd_en  out  1  pixel-RAM read enable.
- ram_rdata  in  COLOR_W  RAM data, valid 1 cycle after ram_rd_en.
- pixel_out  out  COLOR_W  composited pixel.
- pixel_out_valid  out  1  qualifies pixel_out.

Behaviour:
- Reset: all shadow and active registers clear; every pipeline valid clears; reg_rdata, ram_addr, ram_rd_en, pixel_out and pixel_out_valid are 0. A reset mid-stream drops all in-flight pixels.
- Register map (word index):
  - 0: background colour [COLOR_W-1:0].
  - 1: enable mask [N_SPRITES-1:0].
  - 2: status.
  - 4+3i: sprite i {y2[29:20], x1[19:10], y1[9:0]}.
  - 5+3i: sprite i {layer[LAYER_W+9:10], x2[9:0]}.
  - 6+3i: sprite i base address.
  - Coordinate fields are COORD_W wide at offsets 0/10/20 when COORD_W=10.
  - Unmapped writes are ignored; unmapped reads return 0.
  - Reads return the shadow copy.
- Shadowing:
  - Writes land in the shadow copy only.
  - On frame_start, active <= shadow for all fields.
  - A write in the same cycle as frame_start is captured by shadow but not by active; it becomes visible at the next frame_start.
- Hit test (stage 1):
  - Sprite i hits when it is enabled, x1<=pix_x<=x2 and y1<=pix_y<=y2 (inclusive).
  - A sprite with x2<x1 or y2<y1 never hits.
  - Winner is the highest layer; ties go to the lowest index.
  - Registered: hit flag, winner index, dx=pix_x-x1, dy=pix_y-y1.
- Address (stage 2):
  - ram_addr = base + dy*(x2-x1+1) + dx, truncated modulo 2**RAM_ADDR_W.
  - ram_rd_en = stage-1 valid AND hit.
- Stage 3: carries hit and valid alongside the RAM access.
- Output (stage 4):
  - pixel_out = ram_rdata when hit, else the active background colour.
  - pixel_out_valid tracks pix_valid delayed by exactly 4 cycles.
  - Fully pipelined: one request per cycle, no backpressure.
- Active descriptors change only at frame_start. A pixel in flight uses the descriptors sampled at its stage 1.

Optional Feature:
- Macro: SPRITE_COLLISION_EN.
- Defined:
  - Status word 2 bit 0 is a sticky collision flag, set when a valid stage-1 pixel is hit by two or more sprites.
  - Bits [8+N_SPRITES-1:8] are sticky per-sprite participation flags.
  - A read of word 2 returns the current flags and clears them the next cycle. A set in the same cycle as the clear wins.
- Undefined: word 2 reads 0 and no collision logic is built.

Test Plan:
- Reset → all outputs 0. Request (10,10) with no enables → pixel_out=0 (background reset value) at T+4, ram_rd_en never asserted.
- Bg=0xABC. Sprite0 x1=40, x2=45, y1=50, y2=52, base=0, enable=1, frame_start. Request (42,51) → ram_addr=8 at T+2; ram_rdata=0x123 → pixel_out=0x123 at T+4. Requests (39,51) and (46,51) → 0xABC.
- Sprite0 layer 1, sprite1 layer 3 overlapping at (42,51) → sprite1 address used. Equal layers → sprite0 wins.
- Rewrite sprite0 x1=0 without frame_start → output unchanged. After frame_start → new window applies. Write coincident with frame_start → takes effect only at the following frame_start.
- Back-to-back pix_valid for 64 cycles with reset asserted at cycle 20 → pixel_out_valid 0 from the cycle after reset and all outputs 0; recovery is clean after reset deasserts.
- With SPRITE_COLLISION_EN: overlap pixel requested → word 2 reads 0x301 (bit 0 plus sprites 0 and 1). An immediate second read → 0x000.
